// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag field positions, transaction type codes, line geometry, responder states.
// Pure declarations; no latency or flow-control behaviour of its own.
package sysbus_pkg;

    localparam int WRITE_BIT = 12;
    localparam int TYPE_MSB  = 11;
    localparam int TYPE_LSB  = 8;

    localparam logic [3:0] TYPE_MEMORY = 4'h1;

    localparam int LINE_BEATS = 8;

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RRESP,
        WDATA
    } state_t;

    function automatic logic is_memory_type(input logic [3:0] typ);
        return typ == TYPE_MEMORY;
    endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// Line storage for the memory responder: one synchronous write port, one registered read port.
// Read data appears one edge after rd_en and holds until the next rd_en.
// No backpressure; the responder schedules every access.
module sysbus_mem_array #(
    parameter int WORDS = 4096,
    parameter int DW    = 64,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [WORDS];

    // No reset on purpose: contents survive a responder reset and the block maps to RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: accepts 8-beat line reads/writes and answers reads with tagged bursts.
// First read beat READ_LATENCY edges after address accept; beats then back-to-back with no bubble.
// Response beats hold while bus_respack=0; requests stall (bus_reqack=0) until the FSM is idle.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int          BUS_DATA_WIDTH = 64,
    parameter int          BUS_TAG_WIDTH  = 13,
    parameter int          MEM_WORDS      = 4096,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy,
    output logic                      addr_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [BUS_DATA_WIDTH-1:0] BASE      = BUS_DATA_WIDTH'(BASE_ADDR);
    localparam logic [BUS_DATA_WIDTH-1:0] WORDS_W   = BUS_DATA_WIDTH'(MEM_WORDS);
    localparam logic [2:0]                LAST_BEAT = 3'(LINE_BEATS - 1);
    localparam logic [LW-1:0]             LAT_LOAD  = LW'(READ_LATENCY - 1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [2:0]    beat;
    logic [LW-1:0] lat;
    logic          discard;

    logic [BUS_DATA_WIDTH-1:0] req_off;
    logic [BUS_DATA_WIDTH-1:0] req_line;
    logic                      req_in_range;
    logic                      req_is_mem;
    logic                      req_is_wr;
    logic                      req_ok;
    logic [AW-1:0]             req_idx;
    logic                      accept;
    logic                      resp_xfer;
    logic                      wr_xfer;

    logic                      rd_en;
    logic [AW-1:0]             rd_addr;
    logic [BUS_DATA_WIDTH-1:0] rd_dat;
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;

    // Line-aligned word index of the incoming address beat; byte offset bits [5:0] fall away.
    always_comb begin
        req_off      = bus_req - BASE;
        req_line     = (req_off >> 6) << 3;
        req_in_range = (bus_req >= BASE) && ((req_line + BUS_DATA_WIDTH'(7)) < WORDS_W);
        req_is_mem   = is_memory_type(bus_reqtag[TYPE_MSB:TYPE_LSB]);
        req_is_wr    = bus_reqtag[WRITE_BIT];
        req_ok       = req_is_mem && req_in_range;
        req_idx      = req_line[AW-1:0];
        accept       = (state == IDLE) && bus_reqcyc && bus_reqack;
        resp_xfer    = (state == RRESP) && bus_respcyc && bus_respack;
        wr_xfer      = (state == WDATA) && bus_reqcyc && bus_reqack;
    end

    // The array output always runs one word ahead of bus_resp, so an accepted beat can
    // be replaced by the next one on the same edge.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = idx + AW'(beat) + AW'(2);
        case (state)
            IDLE: begin
                rd_en   = accept && !req_is_wr && req_ok;
                rd_addr = req_idx;
            end
            RWAIT: begin
                rd_en   = (lat == '0) && !discard;
                rd_addr = idx + AW'(1);
            end
            RRESP: begin
                rd_en   = resp_xfer && (beat < 3'd6) && !discard;
                rd_addr = idx + AW'(beat) + AW'(2);
            end
            default: begin
                rd_en   = 1'b0;
            end
        endcase
        wr_en   = wr_xfer && !discard;
        wr_addr = idx + AW'(beat);
    end

    sysbus_mem_array #(
        .WORDS (MEM_WORDS),
        .DW    (BUS_DATA_WIDTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (bus_req),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            beat        <= '0;
            lat         <= '0;
            discard     <= 1'b0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            busy        <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus_reqack <= 1'b1;
                    if (accept) begin
                        bus_resptag <= bus_reqtag;
                        idx         <= req_idx;
                        beat        <= '0;
                        lat         <= LAT_LOAD;
                        discard     <= !req_ok;
                        busy        <= 1'b1;
                        if (req_is_mem && !req_in_range) begin
                            addr_err <= 1'b1;
                        end
                        if (req_is_wr) begin
                            state <= WDATA;
                        end else begin
                            state      <= RWAIT;
                            bus_reqack <= 1'b0;
                        end
                    end
                end
                RWAIT: begin
                    if (lat == '0) begin
                        state       <= RRESP;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= discard ? '0 : rd_dat;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                RRESP: begin
                    if (resp_xfer) begin
                        if (beat == LAST_BEAT) begin
                            state       <= IDLE;
                            bus_respcyc <= 1'b0;
                            bus_reqack  <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            beat     <= beat + 3'd1;
                            bus_resp <= discard ? '0 : rd_dat;
                        end
                    end
                end
                WDATA: begin
                    if (wr_xfer) begin
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Randomized and directed bench for sysbus_mem_responder against a line-level memory model.
module tb_sysbus_mem_responder;

    localparam int          MEM_WORDS    = 4096;
    localparam int          READ_LATENCY = 4;
    localparam logic [63:0] BASE_ADDR    = 64'h0;

    logic        clk;
    logic        reset;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        busy;
    logic        addr_err;

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (MEM_WORDS),
        .BASE_ADDR      (BASE_ADDR),
        .READ_LATENCY   (READ_LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_reqack  (bus_reqack),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respcyc (bus_respcyc),
        .bus_respack (bus_respack),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .busy        (busy),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [MEM_WORDS];
    logic        ref_err;
    logic [63:0] wbuf [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_mem(input logic [12:0] tag);
        logic [3:0] typ;
        typ = tag[11:8];
        return typ == 4'h1;
    endfunction

    // Maps a byte address to the first word of its line; returns 0 when out of range.
    function automatic bit ref_map(input logic [63:0] addr, output int idx);
        logic [63:0] w;
        idx = 0;
        if (addr < BASE_ADDR) return 1'b0;
        w = (addr - BASE_ADDR) / 8;
        w = w - (w % 8);
        if (w + 7 >= MEM_WORDS) return 1'b0;
        idx = int'(w);
        return 1'b1;
    endfunction

    task automatic wait_ack(input string tag);
        int n = 0;
        while (bus_reqack !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_timeout"}, 64'(bus_reqack), 64'd1);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [12:0] tag, input bit gaps);
        int idx;
        bit ok;
        wait_ack("wr_wait");
        bus_respack = 1'b1;
        bus_reqcyc  = 1'b1;
        bus_req     = addr;
        bus_reqtag  = tag;
        check("wr_ack_addr", 64'(bus_reqack), 64'd1);
        tick();
        ok = ref_map(addr, idx);
        if (is_mem(tag) && !ok) ref_err = 1'b1;
        check("wr_busy", 64'(busy), 64'd1);
        check("wr_addr_err", 64'(addr_err), 64'(ref_err));
        for (int k = 0; k < 8; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    bus_reqcyc = 1'b0;
                    bus_req    = {$urandom, $urandom};
                    tick();
                    check("wr_gap_ack", 64'(bus_reqack), 64'd1);
                end
            end
            bus_reqcyc = 1'b1;
            bus_req    = wbuf[k];
            check("wr_ack_beat", 64'(bus_reqack), 64'd1);
            tick();
            if (is_mem(tag) && ok) ref_mem[idx + k] = wbuf[k];
        end
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        check("wr_done_busy", 64'(busy), 64'd0);
    endtask

    // mode 0: respack always 1; mode 1: respack 0,0,1 per beat; mode 2: random stalls.
    task automatic do_read(input logic [63:0] addr, input logic [12:0] tag, input int mode,
                           input bit chain, input logic [63:0] naddr, input logic [12:0] ntag);
        int idx;
        int lat;
        int s;
        bit ok;
        logic [63:0] exp;
        wait_ack("rd_wait");
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tag;
        tick();
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        ok = ref_map(addr, idx);
        if (is_mem(tag) && !ok) ref_err = 1'b1;
        check("rd_accept_busy", 64'(busy), 64'd1);
        check("rd_addr_err", 64'(addr_err), 64'(ref_err));
        lat = 0;
        while (bus_respcyc !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(READ_LATENCY));
        for (int k = 0; k < 8; k++) begin
            exp = (is_mem(tag) && ok) ? ref_mem[idx + k] : 64'h0;
            s = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 2));
            for (int j = 0; j <= s; j++) begin
                bus_respack = (j == s);
                if (k == 7 && j == s && chain) begin
                    bus_reqcyc = 1'b1;
                    bus_req    = naddr;
                    bus_reqtag = ntag;
                end
                check("rd_cyc", 64'(bus_respcyc), 64'd1);
                check("rd_data", bus_resp, exp);
                check("rd_tag", 64'(bus_resptag), 64'(tag));
                tick();
            end
        end
        bus_respack = 1'b0;
        check("rd_end_cyc", 64'(bus_respcyc), 64'd0);
        check("rd_end_busy", 64'(busy), 64'd0);
        if (chain) check("coll_ack", 64'(bus_reqack), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int idx;
        bit ok;
        reset       = 1'b1;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        ref_err     = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;

        #12;
        check("rst_reqack", 64'(bus_reqack), 64'd0);
        check("rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("rst_resp", bus_resp, 64'd0);
        check("rst_resptag", 64'(bus_resptag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        #1 reset = 1'b0;
        tick();
        check("idle_ack", 64'(bus_reqack), 64'd1);

        // Directed: write then read, unaligned, backpressure.
        for (int k = 0; k < 8; k++) wbuf[k] = 64'(8'h11 * (k + 1));
        do_write(64'h1000, 13'h1105, 1'b0);
        do_read(64'h1000, 13'h0107, 0, 1'b0, '0, '0);
        do_read(64'h1028, 13'h0109, 0, 1'b0, '0, '0);
        do_read(64'h1000, 13'h0110, 1, 1'b0, '0, '0);

        // Out of range read, then array integrity.
        do_read(64'(MEM_WORDS) * 8 + BASE_ADDR, 13'h0120, 0, 1'b0, '0, '0);
        check("oor_sticky", 64'(addr_err), 64'd1);
        do_read(64'h1000, 13'h0121, 0, 1'b0, '0, '0);

        // Collision between final beat and a new request.
        do_read(64'h1000, 13'h0130, 0, 1'b1, 64'h1000, 13'h0131);
        do_read(64'h1000, 13'h0131, 0, 1'b0, '0, '0);

        // Last valid line, non-MEMORY and out-of-range writes are discarded.
        for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
        do_write(64'(MEM_WORDS - 8) * 8 + BASE_ADDR, 13'h1140, 1'b1);
        do_read(64'(MEM_WORDS - 8) * 8 + BASE_ADDR, 13'h0141, 2, 1'b0, '0, '0);
        for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
        do_write(64'h1000, 13'h1205, 1'b0);
        do_write(64'(MEM_WORDS) * 8 + BASE_ADDR, 13'h1142, 1'b0);
        do_read(64'h1000, 13'h0243, 0, 1'b0, '0, '0);
        do_read(64'h1000, 13'h0144, 0, 1'b0, '0, '0);

        // Reset in the middle of a write burst.
        for (int k = 0; k < 8; k++) wbuf[k] = 64'hA000 + 64'(k);
        wait_ack("rst_wait");
        bus_reqcyc = 1'b1;
        bus_req    = 64'h1000;
        bus_reqtag = 13'h1150;
        tick();
        ok = ref_map(64'h1000, idx);
        for (int k = 0; k < 4; k++) begin
            bus_req = wbuf[k];
            tick();
            ref_mem[idx + k] = wbuf[k];
        end
        #2 reset = 1'b1;
        bus_reqcyc = 1'b0;
        ref_err    = 1'b0;
        #1;
        check("mid_rst_reqack", 64'(bus_reqack), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_respcyc", 64'(bus_respcyc), 64'd0);
        check("mid_rst_resp", bus_resp, 64'd0);
        check("mid_rst_resptag", 64'(bus_resptag), 64'd0);
        check("mid_rst_addr_err", 64'(addr_err), 64'd0);
        #2 reset = 1'b0;
        tick();
        do_read(64'h1000, 13'h0151, 0, 1'b0, '0, '0);

        // Randomized traffic over a pre-initialized region plus off-nominal accesses.
        for (int l = 0; l < 32; l++) begin
            for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
            do_write(64'(l) * 64 + BASE_ADDR, {5'h11, 8'($urandom)}, 1'b1);
        end
        for (int t = 0; t < 150; t++) begin
            logic [63:0] a;
            logic [12:0] tg;
            int r = $urandom_range(0, 9);
            a  = BASE_ADDR + 64'($urandom_range(0, 31)) * 64 + 64'($urandom_range(0, 63));
            if (r == 0) a = BASE_ADDR + 64'(MEM_WORDS) * 8 + 64'($urandom);
            tg = {1'($urandom), 4'h1, 8'($urandom)};
            if (r == 1) tg[11:8] = 4'($urandom_range(2, 15));
            if (tg[12]) begin
                for (int k = 0; k < 8; k++) wbuf[k] = {$urandom, $urandom};
                do_write(a, tg, 1'b1);
            end else begin
                do_read(a, tg, 2, 1'b0, '0, '0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
